// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised uCISC ALU with valid/ready handshakes on
// both sides. Single-cycle ops finish one edge after accept; unsigned
// divide/modulo use an iterative restoring divider (one quotient bit/clock).
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   in_valid     operation presented
//   in_ready     block can accept (high only in IDLE)
//   op_code      operation select, captured on accept
//   source       source operand (s), captured on accept
//   destination  destination operand (d), captured on accept
//   flags        current flags; bit 8 = sign mode, bits 15:5 pass through
//   out_valid    result_out/flags_out/write_flags valid
//   out_ready    consumer takes result
//   result_out   result
//   flags_out    {flags[15:5], divide_error, overflow, carry, negative, zero}
//   write_flags  flags_out is to be written (op_code != 0)
module alu_seq #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DIVISION = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op_code,
   input  logic [WIDTH-1:0] source,
   input  logic [WIDTH-1:0] destination,
   input  logic [15:0]      flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_out,
   output logic [15:0]      flags_out,
   output logic             write_flags
);

   localparam int unsigned H  = WIDTH / 2;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_DONE
   } state_t;

   state_t state;

   // single-cycle datapath, evaluated directly on the presented inputs
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v, alu_dz, alu_z, alu_n;
   logic [WIDTH:0]     sum, diff;
   logic [2*WIDTH-1:0] prod;
   logic               is_div, start_div;

   // divider state
   logic [WIDTH-1:0] div_quo, div_rem, div_den;
   logic [CW-1:0]    div_cnt;
   logic             div_mod;
   logic [10:0]      flags_hi;

   logic [WIDTH:0]   rem_shift, trial;
   logic [WIDTH-1:0] quo_next, rem_next, div_res;

   logic unused_bits;

   assign sum  = {1'b0, destination} + {1'b0, source};
   assign diff = {1'b0, destination} - {1'b0, source};
   assign prod = {{WIDTH{1'b0}}, destination} * {{WIDTH{1'b0}}, source};

   assign is_div    = (op_code == 4'hD) || (op_code == 4'hE);
   assign start_div = (DIVISION != 0) && is_div && (source != '0);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_dz  = 1'b0;
      case (op_code)
         4'h0: alu_res = source;
         4'h1: alu_res = destination & source;
         4'h2: alu_res = destination | source;
         4'h3: alu_res = destination ^ source;
         4'h4: alu_res = ~source;
         // shift amounts >= WIDTH naturally yield 0 / all fill bits
         4'h5: alu_res = destination << source;
         4'h6: begin
            if (flags[8])
               alu_res = $signed(destination) >>> source;
            else
               alu_res = destination >> source;
         end
         4'h7: alu_res = {source[H-1:0], source[WIDTH-1:H]};
         4'h8: alu_res = {source[WIDTH-1:H], {H{1'b0}}};
         4'h9: alu_res = {{H{1'b0}}, source[H-1:0]};
         4'hA: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (destination[WIDTH-1] == source[WIDTH-1]) &&
                      (sum[WIDTH-1] != destination[WIDTH-1]);
         end
         4'hB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (destination[WIDTH-1] != source[WIDTH-1]) &&
                      (diff[WIDTH-1] != destination[WIDTH-1]);
         end
         4'hC: begin
            alu_res = prod[WIDTH-1:0];
            alu_c   = |prod[2*WIDTH-1:WIDTH];
            alu_v   = |prod[2*WIDTH-1:WIDTH];
         end
         4'hD, 4'hE: begin
            // reaches here only for s = 0 or when no divider is built
            alu_res = '0;
            alu_dz  = (DIVISION != 0) && (source == '0);
         end
         default: alu_res = '0;
      endcase
      alu_z = (alu_res == '0) && (op_code != 4'hF);
      alu_n = alu_res[WIDTH-1];
   end

   // one restoring-division step: shift in next dividend bit, try subtract
   always_comb begin
      rem_shift = {div_rem, div_quo[WIDTH-1]};
      trial     = rem_shift - {1'b0, div_den};
      if (trial[WIDTH]) begin
         rem_next = rem_shift[WIDTH-1:0];
         quo_next = {div_quo[WIDTH-2:0], 1'b0};
      end else begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {div_quo[WIDTH-2:0], 1'b1};
      end
      div_res = div_mod ? rem_next : quo_next;
   end

   assign unused_bits = ^{flags[4:0], rem_shift[WIDTH]};

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         result_out  <= '0;
         flags_out   <= '0;
         write_flags <= 1'b0;
         div_quo     <= '0;
         div_rem     <= '0;
         div_den     <= '0;
         div_cnt     <= '0;
         div_mod     <= 1'b0;
         flags_hi    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  flags_hi <= flags[15:5];
                  div_mod  <= (op_code == 4'hE);
                  if (start_div) begin
                     div_quo <= destination;
                     div_den <= source;
                     div_rem <= '0;
                     div_cnt <= '0;
                     state   <= ST_DIV;
                  end else begin
                     result_out  <= alu_res;
                     flags_out   <= {flags[15:5], alu_dz, alu_v, alu_c, alu_n, alu_z};
                     write_flags <= (op_code != 4'h0);
                     state       <= ST_DONE;
                  end
               end
            end
            ST_DIV: begin
               div_quo <= quo_next;
               div_rem <= rem_next;
               div_cnt <= div_cnt + 1'b1;
               if (div_cnt == CW'(WIDTH - 1)) begin
                  result_out  <= div_res;
                  flags_out   <= {flags_hi, 3'b000, div_res[WIDTH-1], div_res == '0};
                  write_flags <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH = 16, DIVISION = 1).
// Expected values come from a plain-arithmetic reference model of the ALU
// rules; directed vectors additionally carry hand-computed results.
module tb_alu_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op_code = '0;
   logic [15:0] source = '0;
   logic [15:0] destination = '0;
   logic [15:0] flags = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result_out;
   logic [15:0] flags_out;
   logic        write_flags;

   int errors = 0;
   int checks = 0;

   alu_seq #(.WIDTH(16), .DIVISION(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op_code     (op_code),
      .source      (source),
      .destination (destination),
      .flags       (flags),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result_out  (result_out),
      .flags_out   (flags_out),
      .write_flags (write_flags)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // reference model: returns {write_flags, flags_out, result}
   function automatic logic [32:0] model(input logic [3:0] op, input logic [15:0] d,
                                         input logic [15:0] s, input logic [15:0] fl);
      int unsigned     dv, sv, r;
      longint unsigned p;
      int              sd;
      bit              c, v, de, z, n, fill;
      dv = d; sv = s; r = 0; c = 0; v = 0; de = 0;
      case (op)
         4'h0: r = sv;
         4'h1: r = dv & sv;
         4'h2: r = dv | sv;
         4'h3: r = dv ^ sv;
         4'h4: r = ~sv & 32'hFFFF;
         4'h5: r = (sv >= 16) ? 0 : ((dv << sv) & 32'hFFFF);
         4'h6: begin
            fill = fl[8] && d[15];
            if (sv >= 16) r = fill ? 32'hFFFF : 0;
            else begin
               r = dv >> sv;
               if (fill) r = r | ((32'hFFFF << (16 - sv)) & 32'hFFFF);
            end
         end
         4'h7: r = ((sv & 32'hFF) << 8) | (sv >> 8);
         4'h8: r = sv & 32'hFF00;
         4'h9: r = sv & 32'h00FF;
         4'hA: begin
            r  = dv + sv;
            c  = (r >> 16) != 0;
            sd = int'($signed(d)) + int'($signed(s));
            v  = (sd > 32767) || (sd < -32768);
            r  = r & 32'hFFFF;
         end
         4'hB: begin
            c  = dv < sv;
            r  = (dv - sv) & 32'hFFFF;
            sd = int'($signed(d)) - int'($signed(s));
            v  = (sd > 32767) || (sd < -32768);
         end
         4'hC: begin
            p = longint'(dv) * longint'(sv);
            r = int'(p & 64'hFFFF);
            c = (p >> 16) != 0;
            v = c;
         end
         4'hD: if (sv == 0) de = 1; else r = dv / sv;
         4'hE: if (sv == 0) de = 1; else r = dv % sv;
         default: r = 0;
      endcase
      z = (r == 0) && (op != 4'hF);
      n = r[15];
      return {op != 4'h0, fl[15:5], de, v, c, n, z, r[15:0]};
   endfunction

   function automatic int model_latency(input logic [3:0] op, input logic [15:0] s);
      return ((op == 4'hD || op == 4'hE) && s != 0) ? 17 : 1;
   endfunction

   // present one op, wait (bounded) for out_valid; outputs left pending
   task automatic start_and_wait(input logic [3:0] op, input logic [15:0] d,
                                 input logic [15:0] s, input logic [15:0] fl,
                                 output int lat, output bit busy_rdy);
      @(negedge clock);
      op_code = op; destination = d; source = s; flags = fl; in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      lat = 1;
      busy_rdy = 1'b0;
      while (out_valid !== 1'b1 && lat < 60) begin
         if (in_ready !== 1'b0) busy_rdy = 1'b1;
         @(posedge clock);
         #1;
         lat++;
      end
   endtask

   task automatic handshake();
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({in_ready, out_valid, write_flags} !== 3'b100) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 100", {in_ready, out_valid, write_flags});
      end
      checks++;
      if ({result_out, flags_out} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got %h/%h expected 0000/0000", result_out, flags_out);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      // {op, d, s, flags, hand-computed result}
      logic [67:0] tbl [14] = '{
         {4'hA, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000},
         {4'hA, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000},
         {4'hB, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE},
         {4'hD, 16'd100,  16'd7,    16'h0000, 16'd14},
         {4'hE, 16'd100,  16'd7,    16'h0000, 16'd2},
         {4'hD, 16'h1234, 16'h0000, 16'h0000, 16'h0000},
         {4'h6, 16'h8000, 16'd4,    16'h0100, 16'hF800},
         {4'h6, 16'h8000, 16'd20,   16'h0100, 16'hFFFF},
         {4'h6, 16'h8000, 16'd4,    16'h0000, 16'h0800},
         {4'h5, 16'h0001, 16'd16,   16'h0000, 16'h0000},
         {4'h0, 16'h0000, 16'h1234, 16'h0000, 16'h1234},
         {4'h7, 16'h0000, 16'h1234, 16'h0000, 16'h3412},
         {4'hC, 16'h0100, 16'h0100, 16'h0000, 16'h0000},
         {4'hF, 16'h0001, 16'h0001, 16'hFFFF, 16'h0000}
      };
      for (int i = 0; i < 14; i++) begin
         logic [3:0]  op;
         logic [15:0] d, s, fl, r;
         logic [32:0] exp;
         int          lat;
         bit          busy;
         {op, d, s, fl, r} = tbl[i];
         exp = model(op, d, s, fl);
         start_and_wait(op, d, s, fl, lat, busy);
         checks++;
         if (result_out !== r) begin
            errors++;
            $display("FAIL dir%0d_const_result: got %h expected %h", i, result_out, r);
         end
         checks++;
         if (flags_out !== exp[31:16]) begin
            errors++;
            $display("FAIL dir%0d_flags: got %h expected %h", i, flags_out, exp[31:16]);
         end
         checks++;
         if (write_flags !== exp[32]) begin
            errors++;
            $display("FAIL dir%0d_write_flags: got %b expected %b", i, write_flags, exp[32]);
         end
         checks++;
         if (lat != model_latency(op, s)) begin
            errors++;
            $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, model_latency(op, s));
         end
         checks++;
         if (busy) begin
            errors++;
            $display("FAIL dir%0d_busy_ready: got in_ready high while busy expected low", i);
         end
         handshake();
      end
      // hand-derived flag words for the first two test-plan adds
   endtask

   task automatic test_add_flags();
      int lat;
      bit busy;
      start_and_wait(4'hA, 16'hFFFF, 16'h0001, 16'h0000, lat, busy);
      checks++;
      if ({write_flags, flags_out} !== 17'h1_0005) begin
         errors++;
         $display("FAIL add_wrap_flags: got %h expected 10005", {write_flags, flags_out});
      end
      handshake();
      start_and_wait(4'hA, 16'h7FFF, 16'h0001, 16'h0000, lat, busy);
      checks++;
      if (flags_out !== 16'h000A) begin
         errors++;
         $display("FAIL add_ovf_flags: got %h expected 000a", flags_out);
      end
      handshake();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         logic [3:0]  op;
         logic [15:0] d, s, fl;
         logic [32:0] exp;
         int          lat;
         bit          busy;
         op = 4'($urandom_range(0, 15));
         d  = 16'($urandom);
         case ($urandom_range(0, 3))
            0: s = 16'($urandom_range(0, 20));
            1: s = 16'h0000;
            default: s = 16'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) d = {d[15], 15'h0};
         fl  = 16'($urandom);
         exp = model(op, d, s, fl);
         start_and_wait(op, d, s, fl, lat, busy);
         checks++;
         if ({write_flags, flags_out, result_out} !== exp) begin
            errors++;
            $display("FAIL rand%0d op=%h d=%h s=%h fl=%h: got %h expected %h",
                     i, op, d, s, fl, {write_flags, flags_out, result_out}, exp);
         end
         checks++;
         if (lat != model_latency(op, s) || busy) begin
            errors++;
            $display("FAIL rand%0d_timing: got lat=%0d busy=%0b expected lat=%0d busy=0",
                     i, lat, busy, model_latency(op, s));
         end
         handshake();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_return_idle: got rdy=%b vld=%b expected 1/0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [32:0] exp, snap;
      int          lat;
      bit          busy;
      exp = model(4'hB, 16'h1234, 16'h4321, 16'hA5A5);
      start_and_wait(4'hB, 16'h1234, 16'h4321, 16'hA5A5, lat, busy);
      snap = {write_flags, flags_out, result_out};
      checks++;
      if (snap !== exp) begin
         errors++;
         $display("FAIL bp_value: got %h expected %h", snap, exp);
      end
      // junk on the input side must be ignored while held in DONE
      in_valid = 1'b1; op_code = 4'h3; source = 16'hFFFF; destination = 16'h0F0F;
      for (int c = 0; c < 5; c++) begin
         @(posedge clock);
         #1;
         checks++;
         if ({out_valid, in_ready, write_flags, flags_out, result_out} !== {2'b10, exp}) begin
            errors++;
            $display("FAIL bp_hold%0d: got %h expected %h", c,
                     {out_valid, in_ready, write_flags, flags_out, result_out}, {2'b10, exp});
         end
      end
      in_valid = 1'b0;
      handshake();
   endtask

   task automatic test_back_to_back();
      logic [32:0] expq[$];
      logic [32:0] exp;
      int          sent = 0, got = 0, cyc = 0;
      bit          both_hi = 0;
      @(negedge clock);
      out_ready = 1'b1;
      while (got < 10 && cyc < 400) begin
         @(negedge clock);
         cyc++;
         if (in_ready && out_valid) both_hi = 1;
         if (out_valid) begin
            exp = (expq.size() > 0) ? expq.pop_front() : 33'h0;
            checks++;
            if ({write_flags, flags_out, result_out} !== exp) begin
               errors++;
               $display("FAIL b2b%0d: got %h expected %h", got, {write_flags, flags_out, result_out}, exp);
            end
            got++;
         end
         if (in_ready) begin
            if (sent < 10) begin
               op_code = 4'($urandom_range(0, 15));
               destination = 16'($urandom);
               source = 16'($urandom_range(0, 40));
               flags = 16'($urandom);
               in_valid = 1'b1;
               expq.push_back(model(op_code, destination, source, flags));
               sent++;
            end else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      checks++;
      if (got != 10 || both_hi) begin
         errors++;
         $display("FAIL b2b_flow: got results=%0d overlap=%0b expected 10/0", got, both_hi);
      end
   endtask

   task automatic test_reset_mid_div();
      bit saw_valid = 0;
      @(negedge clock);
      op_code = 4'hD; destination = 16'd1000; source = 16'd3; flags = '0; in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_out !== 16'h0) begin
         errors++;
         $display("FAIL mid_div_reset: got vld=%b rdy=%b res=%h expected 0/1/0000",
                  out_valid, in_ready, result_out);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(posedge clock);
         #1;
         if (out_valid !== 1'b0) saw_valid = 1;
      end
      checks++;
      if (saw_valid || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_div_after: got saw_valid=%0b rdy=%b expected 0/1", saw_valid, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_add_flags();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_div();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the combinational uCISC ALU. It accepts one operation at a time over a valid/ready handshake and returns the result and updated flags over a second valid/ready handshake. Single-cycle ops complete in one clock; divide/modulo run on an iterative restoring divider. It sits between the decode/operand-fetch stage and register/flag writeback, so the core can stall on long operations.

## Interface
- WIDTH, 16: operand/result width; even, ≥ 8.
- DIVISION, 1: 1 = iterative divider present; 0 = opcodes D/E return 0 in one cycle, with no divide_error.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept (high only in IDLE).
- op_code  in  4  operation select; captured on accept.
- source  in  WIDTH  source operand; captured on accept.
- destination  in  WIDTH  destination operand; captured on accept.
- flags  in  16  current flags; bit 8 = sign mode; bits 15:5 pass through.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- result_out  out  WIDTH  result.
- flags_out  out  16  {flags[15:5], divide_error, overflow, carry, negative, zero}.
- write_flags  out  1  flags_out is to be written (op_code ≠ 0); valid with out_valid.

## Operation
- Accept when in_valid && in_ready; operands, op_code and flags are latched.
- States:
  - IDLE: in_ready = 1. Accepting a non-divide op, or a divide with source = 0, computes the result and goes to DONE. Accepting a divide with source ≠ 0 and DIVISION = 1 goes to DIV.
  - DIV: WIDTH iterations, one quotient bit per clock, MSB first; after the last iteration goes to DONE.
  - DONE: out_valid = 1 and outputs held stable; when out_ready = 1, goes to IDLE.
- Opcodes (d = destination, s = source, N = WIDTH, H = N/2):
  - 0: copy s.
  - 1, 2, 3: and, or, xor.
  - 4: ~s.
  - 5: d << s. Result is 0 if s ≥ N.
  - 6: right shift. Arithmetic when flags[8] = 1, logical otherwise. If s ≥ N, result is all copies of the fill bit.
  - 7: swap halves, {s[H-1:0], s[N-1:H]}.
  - 8: {s[N-1:H], H'b0}.
  - 9: {H'b0, s[H-1:0]}.
  - A: d + s.
  - B: d − s.
  - C: low N bits of d × s.
  - D: unsigned d / s.
  - E: unsigned d % s.
  - F: reserved. Result 0, all generated flags 0, write_flags = 1.
- Flags:
  - zero = (result == 0).
  - negative = result[N-1].
  - carry:
    - add: bit N of the sum.
    - sub: borrow (d < s unsigned).
    - mul: high N bits of the product ≠ 0.
    - all other ops: 0.
  - overflow: two's-complement signed overflow for add/sub; equal to carry for mul; 0 otherwise.
  - divide_error = 1 only for D/E with s = 0 (DIVISION = 1). In that case result = 0 and there is no DIV phase.
- Inputs other than out_ready are ignored outside IDLE. in_valid may be held high across results.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, result_out = 0, flags_out = 0, write_flags = 0, divider registers 0.
- Non-divide ops and divide-by-zero: out_valid rises on the first clock edge after the accept.
- Divide with s ≠ 0: out_valid rises WIDTH + 1 edges after the accept (17 for WIDTH = 16).
- Throughput: at most one op per 2 clocks. in_ready returns the cycle after the out_valid && out_ready handshake.
- Backpressure: in DONE with out_ready = 0, all outputs hold indefinitely.
- Reset asserted mid-DIV or in DONE: the operation is aborted and no out_valid is produced; after release the block is in IDLE with in_ready = 1.
- Consumer-side simultaneity: accept happens only in IDLE, so no accept and output handshake can occur in the same cycle.

## Test plan
- ADD d = 0xFFFF, s = 0x0001 -> result 0x0000; zero = 1, carry = 1, overflow = 0, negative = 0; out_valid one edge after accept; write_flags = 1.
- ADD d = 0x7FFF, s = 0x0001 -> 0x8000, negative = 1, overflow = 1, carry = 0. SUB d = 0x0003, s = 0x0005 -> 0xFFFE, carry = 1.
- DIV d = 100, s = 7 -> 14; MOD (E) d = 100, s = 7 -> 2. out_valid exactly 17 edges after accept; in_ready low throughout. DIV with s = 0 -> result 0, divide_error = 1, latency 1.
- Shift right, flags[8] = 1, d = 0x8000: s = 4 -> 0xF800; s = 20 -> 0xFFFF. With flags[8] = 0, s = 4 -> 0x0800. Shift left d = 0x0001, s = 16 -> 0x0000, zero = 1.
- COPY s = 0x1234 -> result 0x1234, write_flags = 0. SWAP s = 0x1234 -> 0x3412. MUL d = 0x0100, s = 0x0100 -> 0x0000, carry = 1, overflow = 1, zero = 1.
- Hold out_ready low 5 cycles in DONE -> outputs stable, in_ready = 0. Then assert reset on the 8th cycle of a DIV -> out_valid stays 0, and in_ready = 1 after release.
